// File: rtl/wb_mem_bank_split.sv
// Wishbone slave that splits one word-addressed window across
// NUM_BANKS core SRAM ports, with ack/err handshake, timeout and abort drain.
module wb_mem_bank_split #(
    parameter int NUM_BANKS = 2,
    parameter int BANK_AW   = 10,
    parameter int TIMEOUT   = 255,
    localparam int SELW     = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
) (
    input  logic                          wb_clk_i,
    input  logic                          wb_rst_ni,
    input  logic                          wbs_cyc_i,
    input  logic                          wbs_stb_i,
    input  logic                          wbs_we_i,
    input  logic [3:0]                    wbs_sel_i,
    input  logic [SELW+BANK_AW-1:0]       wbs_adr_i,
    input  logic [31:0]                   wbs_dat_i,
    output logic [31:0]                   wbs_dat_o,
    output logic                          wbs_ack_o,
    output logic                          wbs_err_o,
    output logic [NUM_BANKS-1:0]          bank_req_o,
    output logic [NUM_BANKS-1:0]          bank_we_o,
    output logic [4*NUM_BANKS-1:0]        bank_be_o,
    output logic [BANK_AW*NUM_BANKS-1:0]  bank_addr_o,
    output logic [32*NUM_BANKS-1:0]       bank_wdata_o,
    input  logic [NUM_BANKS-1:0]          bank_rvalid_i,
    input  logic [32*NUM_BANKS-1:0]       bank_rdata_i
);

    localparam int NSLOT = 1 << SELW;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_REQ   = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_ACK   = 3'd3;
    localparam logic [2:0] S_ERR   = 3'd4;
    localparam logic [2:0] S_DRAIN = 3'd5;

    logic [2:0]           state;
    logic [SELW-1:0]      idx_q;
    logic [BANK_AW-1:0]   addr_q;
    logic [3:0]           be_q;
    logic                 we_q;
    logic [31:0]          wdata_q;
    logic [15:0]          cnt;
    logic [NUM_BANKS-1:0] req_q;
    logic [31:0]          dat_q;
    logic                 ack_q;
    logic                 err_q;

    logic [SELW-1:0]      in_idx;
    logic [NSLOT-1:0]     bank_ok;
    logic [NSLOT-1:0]     rv_pad;
    logic                 rv_hit;
    logic                 to_hit;
    logic                 accept;
    logic [31:0]          rdata_sel;
    logic [NUM_BANKS-1:0] in_onehot;

    assign in_idx = wbs_adr_i[SELW+BANK_AW-1 -: SELW];
    assign rv_pad = NSLOT'(bank_rvalid_i);
    assign rv_hit = rv_pad[idx_q];
    assign to_hit = (cnt == 16'(TIMEOUT));
    assign accept = wbs_cyc_i & wbs_stb_i & ~ack_q & ~err_q;

    // Index slots beyond NUM_BANKS decode to an error response.
    for (genvar g = 0; g < NSLOT; g++) begin : g_ok
        assign bank_ok[g] = (g < NUM_BANKS);
    end

    // Select the response data of the latched bank and decode the incoming request bank.
    always_comb begin
        rdata_sel = '0;
        in_onehot = '0;
        for (int i = 0; i < NUM_BANKS; i++) begin
            if (SELW'(i) == idx_q) rdata_sel = bank_rdata_i[32*i +: 32];
            if (SELW'(i) == in_idx) in_onehot[i] = 1'b1;
        end
    end

    // Request/response FSM with registered outputs.
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_ni) begin
            state   <= S_IDLE;
            idx_q   <= '0;
            addr_q  <= '0;
            be_q    <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            cnt     <= '0;
            req_q   <= '0;
            dat_q   <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            req_q <= '0;
            ack_q <= 1'b0;
            err_q <= 1'b0;
            dat_q <= '0;
            unique case (state)
                S_IDLE: begin
                    if (accept) begin
                        idx_q   <= in_idx;
                        addr_q  <= wbs_adr_i[BANK_AW-1:0];
                        be_q    <= wbs_sel_i;
                        we_q    <= wbs_we_i;
                        wdata_q <= wbs_dat_i;
                        if (bank_ok[in_idx]) begin
                            req_q <= in_onehot;
                            state <= S_REQ;
                        end else begin
                            err_q <= 1'b1;
                            state <= S_ERR;
                        end
                    end
                end
                S_REQ: begin
                    cnt   <= '0;
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    cnt <= cnt + 16'd1;
                    if (rv_hit) begin
                        dat_q <= rdata_sel;
                        ack_q <= 1'b1;
                        state <= S_ACK;
                    end else if (!wbs_cyc_i) begin
                        state <= S_DRAIN;
                    end else if (to_hit) begin
                        err_q <= 1'b1;
                        state <= S_ERR;
                    end
                end
                S_ACK:   state <= S_IDLE;
                S_ERR:   state <= S_IDLE;
                S_DRAIN: begin
                    cnt <= cnt + 16'd1;
                    if (rv_hit || to_hit) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign wbs_dat_o    = dat_q;
    assign wbs_ack_o    = ack_q;
    assign wbs_err_o    = err_q;
    assign bank_req_o   = req_q;
    assign bank_we_o    = {NUM_BANKS{we_q}};
    assign bank_be_o    = {NUM_BANKS{be_q}};
    assign bank_addr_o  = {NUM_BANKS{addr_q}};
    assign bank_wdata_o = {NUM_BANKS{wdata_q}};

endmodule
